next_pc_predictor: RTL and testbench
====================================

NEXT_PC_PREDICTOR -- requirements
Module: next_pc_predictor

Interface
REQ-001 SHALL have parameter XLEN, 32, address/data width.
REQ-002 SHALL have parameter BTB_DEPTH, 16, branch-target-buffer entries; power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, 0, PC value after reset.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port stall  input  1  hold fetch PC.
REQ-007 SHALL have port ex_valid  input  1  EX-stage instruction valid.
REQ-008 SHALL have port ex_pc  input  XLEN  PC of EX instruction.
REQ-009 SHALL have port ex_npcop  input  3  000 PLUS4, 001 BRANCH, 010 JUMP, 100 JALR; others treated as PLUS4.
REQ-010 SHALL have port ex_taken  input  1  branch condition result.
REQ-011 SHALL have port ex_imm  input  XLEN  branch/jump offset.
REQ-012 SHALL have port ex_aluout  input  XLEN  JALR target source.
REQ-013 SHALL have ports ex_pred_taken (input, 1) and ex_pred_target (input, XLEN): prediction carried down pipe with the EX instruction.
REQ-014 SHALL have port pc  output  XLEN  registered fetch PC.
REQ-015 SHALL have ports pred_taken (output, 1) and pred_target (output, XLEN): combinational prediction for current pc.
REQ-016 SHALL have port flush  output  1  combinational mispredict; kills IF/ID.

Function
REQ-017 SHALL compute actual_taken = ex_valid & ((BRANCH & ex_taken) | JUMP | JALR).
REQ-018 SHALL compute actual_target = ex_pc+ex_imm for BRANCH/JUMP; {ex_aluout[XLEN-1:1],1'b0} for JALR; ex_pc+4 otherwise; all sums modulo 2^XLEN, wrap-around silent.
REQ-019 SHALL assert flush when ex_valid & (actual_taken != ex_pred_taken | (actual_taken & actual_target != ex_pred_target)).
REQ-020 SHALL load pc next cycle by priority: rst -> RESET_PC; flush -> actual_taken ? actual_target : ex_pc+4; stall -> hold; pred_taken -> pred_target; else pc+4.
REQ-021 SHALL give flush priority over stall in the same cycle.
REQ-022 SHALL index the BTB directly-mapped by pc[log2(BTB_DEPTH)+1:2], tag = remaining upper bits; entry = valid, tag, target, type (branch/jump), 2-bit counter.
REQ-023 SHALL assert pred_taken on valid tag hit with type=jump or counter >= 2; pred_target = entry target, else pc+4.
REQ-024 SHALL, when ex_valid and op is BRANCH/JUMP/JALR, update the entry indexed by ex_pc at clock edge, one-cycle write latency, no read bypass.
REQ-025 SHALL on taken with tag miss allocate/replace: target=actual_target, counter=2 (jump: 3).
REQ-026 SHALL on tag hit increment counter if taken, decrement if not, saturating at 3 and 0; rewrite target on taken.
REQ-027 SHALL not allocate on a not-taken branch miss.
REQ-028 SHALL perform BTB updates regardless of stall.

Reset
REQ-029 SHALL on rst set pc=RESET_PC and clear all BTB valid bits in that cycle; targets/counters not reset.
REQ-030 SHALL ignore ex_* updates in a reset cycle; reset mid-redirect discards the redirect.
REQ-031 SHALL drive pred_taken=0, pred_target=RESET_PC+4 in the first cycle after reset.

Configuration
REQ-032 SHALL, with NPC_BTB_PREDICT_EN defined, include the BTB per REQ-022..REQ-028.
REQ-033 SHALL, without NPC_BTB_PREDICT_EN, omit BTB storage, tie pred_taken=0, pred_target=pc+4; every taken control op flushes.

Verification
REQ-034 SHALL cover: rst then 3 idle cycles -> pc 0,4,8,C; flush=0.
REQ-035 SHALL cover: ex BRANCH at 0x10, imm 0x20, taken, pred 0 -> flush=1, pc=0x30 next; later fetch 0x10 -> pred_taken=1, pred_target=0x30.
REQ-036 SHALL cover: same branch not taken twice after allocation -> counter 2->1->0, pred_taken=0 at 0x10.
REQ-037 SHALL cover: JALR ex_aluout=0x101 with stall=1 -> flush=1, pc=0x100 despite stall.
REQ-038 SHALL cover: entries 0x10 and 0x10+4*BTB_DEPTH alias -> second replaces first; 0x10 misses.
REQ-039 SHALL cover: build without NPC_BTB_PREDICT_EN, repeat REQ-035 -> second fetch pred_taken=0, flush again.

Source files
------------

// File: rtl/next_pc_predictor.sv
// Fetch PC register with EX-stage redirect and an optional direct-mapped BTB.
// Define NPC_BTB_PREDICT_EN to build the BTB; otherwise fetch always predicts pc+4.
module next_pc_predictor #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 16,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_npcop,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_aluout,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            flush
);

  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  if (BTB_DEPTH < 2 || (BTB_DEPTH & (BTB_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BTB_DEPTH must be a power of two and at least 2");
  end

  logic            is_branch;
  logic            is_jump;
  logic            is_jalr;
  logic            actual_taken;
  logic [XLEN-1:0] actual_target;
  logic [XLEN-1:0] ex_seq_pc;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_q;

  // Resolve the EX instruction; unknown op codes behave as sequential flow.
  always_comb begin
    is_branch    = (ex_npcop == OP_BRANCH);
    is_jump      = (ex_npcop == OP_JUMP);
    is_jalr      = (ex_npcop == OP_JALR);
    ex_seq_pc    = ex_pc + XLEN'(4);
    actual_taken = ex_valid & ((is_branch & ex_taken) | is_jump | is_jalr);
    if (is_branch || is_jump) begin
      actual_target = ex_pc + ex_imm;
    end else if (is_jalr) begin
      actual_target = ex_aluout & ~XLEN'(1);
    end else begin
      actual_target = ex_seq_pc;
    end
    flush = ex_valid & ((actual_taken != ex_pred_taken) |
                        (actual_taken & (actual_target != ex_pred_target)));
  end

  // A redirect must win over stall so the wrong-path fetch is never held.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (flush) begin
      pc_d = actual_taken ? actual_target : ex_seq_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

`ifdef NPC_BTB_PREDICT_EN
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic [BTB_DEPTH-1:0] btb_valid_q;
  logic [BTB_DEPTH-1:0] btb_valid_d;
  logic [BTB_DEPTH-1:0] btb_jump_q;
  logic [TAG_W-1:0]     btb_tag_q    [BTB_DEPTH];
  logic [XLEN-1:0]      btb_target_q [BTB_DEPTH];
  logic [1:0]           btb_ctr_q    [BTB_DEPTH];

  logic             is_ctrl;
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic             wr_en;
  logic             wr_jump;
  logic [1:0]       wr_ctr;
  logic [XLEN-1:0]  wr_target;

  always_comb begin
    rd_idx      = pc_q[IDX_W+1:2];
    rd_tag      = pc_q[XLEN-1:IDX_W+2];
    rd_hit      = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
    pred_taken  = rd_hit && (btb_jump_q[rd_idx] || btb_ctr_q[rd_idx][1]);
    pred_target = pred_taken ? btb_target_q[rd_idx] : pc_q + XLEN'(4);
  end

  // Train on every resolved control op; a not-taken miss leaves the table alone.
  always_comb begin
    is_ctrl     = is_branch | is_jump | is_jalr;
    wr_idx      = ex_pc[IDX_W+1:2];
    wr_tag      = ex_pc[XLEN-1:IDX_W+2];
    wr_hit      = btb_valid_q[wr_idx] && (btb_tag_q[wr_idx] == wr_tag);
    wr_en       = 1'b0;
    wr_jump     = btb_jump_q[wr_idx];
    wr_ctr      = btb_ctr_q[wr_idx];
    wr_target   = btb_target_q[wr_idx];
    btb_valid_d = btb_valid_q;
    if (ex_valid && is_ctrl) begin
      if (wr_hit) begin
        wr_en = 1'b1;
        if (actual_taken) begin
          wr_target = actual_target;
          if (wr_ctr != 2'd3) wr_ctr = wr_ctr + 2'd1;
        end else if (wr_ctr != 2'd0) begin
          wr_ctr = wr_ctr - 2'd1;
        end
      end else if (actual_taken) begin
        wr_en               = 1'b1;
        wr_target           = actual_target;
        wr_jump             = is_jump | is_jalr;
        wr_ctr              = wr_jump ? 2'd3 : 2'd2;
        btb_valid_d[wr_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btb_valid_q <= '0;
    end else begin
      btb_valid_q <= btb_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      btb_tag_q[wr_idx]    <= wr_tag;
      btb_target_q[wr_idx] <= wr_target;
      btb_ctr_q[wr_idx]    <= wr_ctr;
      btb_jump_q[wr_idx]   <= wr_jump;
    end
  end
`else
  always_comb begin
    pred_taken  = 1'b0;
    pred_target = pc_q + XLEN'(4);
  end
`endif

endmodule

// File: tb/tb_next_pc_predictor.sv
// Bench for next_pc_predictor: expected fetch PCs are queued as stimulus is driven
// and compared after each rising edge; combinational outputs are checked inline.
module tb_next_pc_predictor;

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;
`ifdef NPC_BTB_PREDICT_EN
  localparam logic BTB_ON = 1'b1;
`else
  localparam logic BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_npcop;
  logic        ex_taken;
  logic [31:0] ex_imm;
  logic [31:0] ex_aluout;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] sb_exp;

  next_pc_predictor #(.XLEN(32), .BTB_DEPTH(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_npcop(ex_npcop), .ex_taken(ex_taken), .ex_imm(ex_imm), .ex_aluout(ex_aluout),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .pc(pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush)
  );

  always #5 clk = ~clk;

  // Scoreboard: one queued PC is consumed per rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      tests_run++;
      if (pc !== sb_exp) begin
        tests_failed++;
        $display("FAIL pc_scoreboard: got %h expected %h at %0t", pc, sb_exp, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clr_ex();
    ex_valid = 1'b0; ex_pc = '0; ex_npcop = OP_PLUS4; ex_taken = 1'b0;
    ex_imm = '0; ex_aluout = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  task automatic drive_ex(input logic [2:0] op, input logic [31:0] epc, input logic tk,
                          input logic [31:0] imm, input logic [31:0] alu,
                          input logic ptk, input logic [31:0] ptgt);
    ex_valid = 1'b1; ex_npcop = op; ex_pc = epc; ex_taken = tk; ex_imm = imm;
    ex_aluout = alu; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; stall = 1'b0; clr_ex(); exp_q.push_back(32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); rst = 1'b0;
      #1;
      tests_run++;
      if (flush !== 1'b0) begin
        tests_failed++; $display("FAIL reset_flush: got %b expected 0 (k=%0d)", flush, k);
      end
      tests_run++;
      if (pred_taken !== 1'b0 || pred_target !== 32'(4 * k + 4)) begin
        tests_failed++;
        $display("FAIL reset_pred: got %b/%h expected 0/%h", pred_taken, pred_target, 32'(4 * k + 4));
      end
      exp_q.push_back(32'(4 * k + 4));
    end
  endtask

  task automatic test_branch_redirect();
    @(negedge clk);
    drive_ex(OP_BRANCH, 32'h10, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0);
    #1;
    tests_run++;
    if (flush !== 1'b1) begin tests_failed++; $display("FAIL branch_flush: got %b expected 1", flush); end
    exp_q.push_back(32'h30);
    // Jump back to 0x10 with a negative offset to refetch the branch.
    @(negedge clk);
    drive_ex(OP_JUMP, 32'h200, 1'b0, 32'hFFFF_FE10, 32'h0, 1'b0, 32'h0);
    #1;
    tests_run++;
    if (flush !== 1'b1) begin tests_failed++; $display("FAIL jump_flush: got %b expected 1", flush); end
    exp_q.push_back(32'h10);
    @(negedge clk);
    drive_ex(OP_BRANCH, 32'h10, 1'b1, 32'h20, 32'h0, BTB_ON, BTB_ON ? 32'h30 : 32'h14);
    #1;
    tests_run++;
    if (pred_taken !== BTB_ON) begin
      tests_failed++; $display("FAIL refetch_pred_taken: got %b expected %b", pred_taken, BTB_ON);
    end
    tests_run++;
    if (pred_target !== (BTB_ON ? 32'h30 : 32'h14)) begin
      tests_failed++;
      $display("FAIL refetch_pred_target: got %h expected %h", pred_target, BTB_ON ? 32'h30 : 32'h14);
    end
    tests_run++;
    if (flush !== !BTB_ON) begin
      tests_failed++; $display("FAIL refetch_flush: got %b expected %b", flush, !BTB_ON);
    end
    exp_q.push_back(32'h30);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    drive_ex(OP_BRANCH, 32'hFFFF_FFF0, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0);
    #1;
    tests_run++;
    if (flush !== 1'b1) begin tests_failed++; $display("FAIL wrap_flush: got %b expected 1", flush); end
    exp_q.push_back(32'h10);
  endtask

  task automatic test_jalr_stall();
    @(negedge clk); stall = 1'b1;
    drive_ex(OP_JALR, 32'h40, 1'b0, 32'h0, 32'h101, 1'b0, 32'h0);
    #1;
    tests_run++;
    if (flush !== 1'b1) begin tests_failed++; $display("FAIL jalr_flush: got %b expected 1", flush); end
    exp_q.push_back(32'h100);
    @(negedge clk); clr_ex();
    #1;
    tests_run++;
    if (flush !== 1'b0) begin tests_failed++; $display("FAIL stall_idle_flush: got %b expected 0", flush); end
    exp_q.push_back(32'h100);
    @(negedge clk);
    drive_ex(OP_JALR, 32'h40, 1'b0, 32'h0, 32'h101, 1'b1, 32'h100);
    #1;
    tests_run++;
    if (flush !== 1'b0) begin tests_failed++; $display("FAIL jalr_hit_flush: got %b expected 0", flush); end
    exp_q.push_back(32'h100);
    @(negedge clk);
    drive_ex(OP_JALR, 32'h40, 1'b0, 32'h0, 32'h101, 1'b1, 32'h104);
    #1;
    tests_run++;
    if (flush !== 1'b1) begin tests_failed++; $display("FAIL jalr_badtgt_flush: got %b expected 1", flush); end
    exp_q.push_back(32'h100);
    @(negedge clk);
    drive_ex(OP_BRANCH, 32'h100, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0);
    exp_q.push_back(32'h100);
    @(negedge clk); clr_ex();
    #1;
    tests_run++;
    if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL nt_no_alloc: got %b expected 0", pred_taken); end
    exp_q.push_back(32'h100);
    @(negedge clk); stall = 1'b0;
    drive_ex(OP_BRANCH, 32'h60, 1'b0, 32'h20, 32'h0, 1'b1, 32'h80);
    #1;
    tests_run++;
    if (flush !== 1'b1) begin tests_failed++; $display("FAIL nt_mispred_flush: got %b expected 1", flush); end
    exp_q.push_back(32'h64);
    @(negedge clk);
    drive_ex(3'b011, 32'h70, 1'b1, 32'h40, 32'h0, 1'b0, 32'h0);
    #1;
    tests_run++;
    if (flush !== 1'b0) begin tests_failed++; $display("FAIL other_op_flush: got %b expected 0", flush); end
    exp_q.push_back(32'h68);
    @(negedge clk); clr_ex(); ex_pred_taken = 1'b1; ex_pred_target = 32'h80;
    #1;
    tests_run++;
    if (flush !== 1'b0) begin tests_failed++; $display("FAIL invalid_ex_flush: got %b expected 0", flush); end
    exp_q.push_back(32'h6C);
  endtask

  task automatic test_reset_mid_redirect();
    @(negedge clk); rst = 1'b1;
    drive_ex(OP_BRANCH, 32'h10, 1'b1, 32'h20, 32'h0, 1'b0, 32'h0);
    exp_q.push_back(32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); rst = 1'b0; clr_ex();
      exp_q.push_back(32'(4 * k));
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h14) begin
      tests_failed++;
      $display("FAIL reset_discard: got %b/%h expected 0/00000014", pred_taken, pred_target);
    end
    exp_q.push_back(32'h14);
  endtask

  task automatic test_back_to_back();
    logic [31:0] cur;
    cur = 32'h14;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      stall = 1'($urandom_range(0, 1));
      cur = stall ? cur : cur + 32'h4;
      exp_q.push_back(cur);
    end
    @(negedge clk); stall = 1'b0;
  endtask

`ifdef NPC_BTB_PREDICT_EN
  task automatic test_counter_alias();
    bit tk_seq [10];
    bit pt_seq [10];
    tk_seq = '{0, 1, 0, 0, 0, 1, 1, 1, 1, 0};
    pt_seq = '{1, 0, 1, 0, 0, 0, 0, 1, 1, 1};
    @(negedge clk); rst = 1'b1; clr_ex(); stall = 1'b0; exp_q.push_back(32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); rst = 1'b0;
      exp_q.push_back(32'(4 * k));
    end
    @(negedge clk); stall = 1'b1;
    drive_ex(OP_BRANCH, 32'h10, 1'b1, 32'h20, 32'h0, 1'b1, 32'h30);
    #1;
    tests_run++;
    if (pred_taken !== 1'b0) begin tests_failed++; $display("FAIL no_bypass: got %b expected 0", pred_taken); end
    exp_q.push_back(32'h10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive_ex(OP_BRANCH, 32'h10, tk_seq[i], 32'h20, 32'h0, tk_seq[i], tk_seq[i] ? 32'h30 : 32'h0);
      #1;
      tests_run++;
      if (pred_taken !== pt_seq[i] || pred_target !== (pt_seq[i] ? 32'h30 : 32'h14)) begin
        tests_failed++;
        $display("FAIL counter_step%0d: got %b/%h expected %b/%h", i, pred_taken, pred_target,
                 pt_seq[i], pt_seq[i] ? 32'h30 : 32'h14);
      end
      exp_q.push_back(32'h10);
    end
    @(negedge clk);
    drive_ex(OP_BRANCH, 32'h50, 1'b1, 32'h30, 32'h0, 1'b1, 32'h80);
    #1;
    tests_run++;
    if (pred_taken !== 1'b1) begin tests_failed++; $display("FAIL alias_before: got %b expected 1", pred_taken); end
    exp_q.push_back(32'h10);
    @(negedge clk); clr_ex();
    #1;
    tests_run++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h14) begin
      tests_failed++; $display("FAIL alias_after: got %b/%h expected 0/00000014", pred_taken, pred_target);
    end
    exp_q.push_back(32'h10);
    @(negedge clk); stall = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; stall = 1'b0; clr_ex();
    test_reset();
    test_branch_redirect();
    test_wrap();
    test_jalr_stall();
    test_reset_mid_redirect();
    test_back_to_back();
`ifdef NPC_BTB_PREDICT_EN
    test_counter_alias();
`endif
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
